// File: rtl/if_id.sv
// if_id: fetch-to-decode pipeline register with CP0 tags, stall hold, flush bubble and stall counter
module if_id #(
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [31:0] IMEM_TOP  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc8_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc8_d,
    output logic [4:0]  excode_d,
    output logic        bd_d,
    output logic        valid_d,
    output logic [15:0] stall_cnt
);

    logic [31:0] pc_f;
    logic        adel;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        is_br_d;

    // Fetch-address check and branch/jump decode of the instruction now in D; a bubble never counts as a branch
    always_comb begin
        pc_f    = pc8_f - 32'd8;
        adel    = (pc_f[1:0] != 2'b00) || (pc_f < IMEM_BASE) || (pc_f > IMEM_TOP);
        op      = instr_d[31:26];
        fn      = instr_d[5:0];
        is_br_d = valid_d && ((op inside {6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07}) ||
                              (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)));
    end

    // Pipeline register: flush beats stall, stall holds and counts, otherwise load with tags
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            instr_d   <= 32'h0;
            pc8_d     <= 32'h0000_3008;
            excode_d  <= 5'd0;
            bd_d      <= 1'b0;
            valid_d   <= 1'b0;
            stall_cnt <= 16'h0;
        end else if (flush) begin
            instr_d  <= 32'h0;
            pc8_d    <= pc8_f;
            excode_d <= 5'd0;
            bd_d     <= 1'b0;
            valid_d  <= 1'b0;
        end else if (stall) begin
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end else begin
            instr_d  <= adel ? 32'h0 : instr_f;
            pc8_d    <= pc8_f;
            excode_d <= adel ? 5'd4 : 5'd0;
            bd_d     <= is_br_d;
            valid_d  <= 1'b1;
        end
    end

endmodule

// File: doc/if_id.md
# if_id

Pipeline register between the fetch stage and the decode stage of the five-stage MIPS core. Each cycle it captures the fetched instruction and its PC+8, and attaches per-instruction tags for CP0: fetch-address exception code, delay-slot flag and valid bit. It implements hold on `stall`, bubble insertion on `flush`, and a saturating stall-cycle counter for debug.

## Interface
- `IMEM_BASE`, 32'h0000_3000, lowest legal instruction address
- `IMEM_TOP`, 32'h0000_6FFC, highest legal instruction address (inclusive)
- `clk`  in  1  pipeline clock, rising edge
- `clr_n`  in  1  asynchronous active-low reset
- `stall`  in  1  hold D-stage contents (hazard unit)
- `flush`  in  1  replace next D-stage contents with a bubble (interrupt/exception/eret)
- `instr_f`  in  32  instruction from fetch
- `pc8_f`  in  32  PC+8 of `instr_f`
- `instr_d`  out  32  instruction presented to decode
- `pc8_d`  out  32  PC+8 of `instr_d`
- `excode_d`  out  5  fetch exception code: 0 none, 4 AdEL
- `bd_d`  out  1  `instr_d` sits in a branch/jump delay slot
- `valid_d`  out  1  `instr_d` is a real instruction (0 = bubble)
- `stall_cnt`  out  16  saturating count of stalled cycles since reset

## Operation
- Fetch address `pc_f = pc8_f - 8` (32-bit modular subtraction).
- AdEL condition: `pc_f[1:0] != 0`, or `pc_f < IMEM_BASE`, or `pc_f > IMEM_TOP` (unsigned compare).
- Branch/jump decode on the current `instr_d` (only when `valid_d=1`): opcode 6'h04 beq, 6'h05 bne, 6'h06 blez, 6'h07 bgtz, 6'h01 regimm (bltz/bgez), 6'h02 j, 6'h03 jal; opcode 0 with funct 6'h08 jr or 6'h09 jalr. Result `is_br_d`.
- Per-edge update, priority highest first:
  - `flush=1`: `instr_d<=0`, `valid_d<=0`, `bd_d<=0`, `excode_d<=0`, `pc8_d<=pc8_f`. Flush overrides stall.
  - `stall=1`: all D outputs hold; `stall_cnt` increments unless already 16'hFFFF.
  - otherwise load: `pc8_d<=pc8_f`, `valid_d<=1`, `bd_d<=is_br_d`; if AdEL then `instr_d<=0`, `excode_d<=4`; else `instr_d<=instr_f`, `excode_d<=0`.
- `stall_cnt` changes only on stalled edges with `flush=0`; cleared only by reset.
- `bd_d` relates to the instruction currently in D, so a branch held by stall keeps its slot-successor un-tagged until the branch leaves D. The successor is tagged on the load edge that moves it in.
- A bubble never sets `bd_d` on its successor, because `is_br_d` is gated by `valid_d`.

## Timing
- Latency: one cycle, fetch to decode, on every load edge. No combinational path from inputs to outputs.
- Reset (`clr_n` low, asynchronous, effective immediately): `instr_d=0`, `pc8_d=32'h0000_3008`, `excode_d=0`, `bd_d=0`, `valid_d=0`, `stall_cnt=0`.
- Reset release is sampled synchronously. The first edge with `clr_n` high performs a normal update.
- Reset asserted mid-stall or mid-flush: all outputs go immediately to reset values, and `stall_cnt` clears.
- Back-to-back flush: each flush edge produces a bubble; `pc8_d` tracks `pc8_f` on every such edge.
- `stall` and `flush` together: the flush path is taken and `stall_cnt` does not increment.
- `stall_cnt` at 16'hFFFF with `stall=1` stays 16'hFFFF (no wrap).

## Test plan
- Reset then load: `clr_n` pulse low, then `instr_f=32'h3C01_1234`, `pc8_f=32'h3008` for one edge -> `instr_d=32'h3C01_1234`, `pc8_d=32'h3008`, `valid_d=1`, `bd_d=0`, `excode_d=0`.
- Delay slot: load beq `32'h1022_0003` (pc8 0x300C), then `32'h0000_0000` (pc8 0x3010) -> second has `bd_d=1`. Repeat with a stall of 3 cycles between -> `bd_d=1` still on successor, `stall_cnt=3`, outputs held during stall.
- AdEL: `pc8_f=32'h300A` (misaligned), then `pc8_f=32'h7008` (above top) -> `instr_d=0`, `excode_d=4`, `valid_d=1` in both cases; `pc8_f=32'h2FFC` (below base) -> `excode_d=4`.
- Flush priority: `stall=1` and `flush=1` with `pc8_f=32'h4188` -> `valid_d=0`, `instr_d=0`, `bd_d=0`, `pc8_d=32'h4188`, `stall_cnt` unchanged; following load after jr in D preceded by bubble gives `bd_d=0`.
- Counter saturation: hold `stall=1` for 65540 cycles -> `stall_cnt=16'hFFFF`, no wrap; assert `clr_n` low mid-stall asynchronously (between edges) -> all outputs at reset values before next edge.
